// File: rtl/scm_pkg.sv
// ============================================================================
// Module : scm_pkg
// Brief  : Shared sizing constants for the standard-cell memory.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package scm_pkg;

  localparam int SCM_ADDR_WIDTH = 6;
  localparam int SCM_DATA_WIDTH = 64;
  localparam int NUM_ROWS       = 2 ** SCM_ADDR_WIDTH;

endpackage

`default_nettype wire

// File: rtl/scm_65_if.sv
// ============================================================================
// Module : scm_65_if
// Brief  : Write/read port bundle of the standard-cell memory.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface scm_65_if #(
  parameter int ADDR_WIDTH = scm_pkg::SCM_ADDR_WIDTH,
  parameter int DATA_WIDTH = scm_pkg::SCM_DATA_WIDTH
);

  logic [DATA_WIDTH-1:0] DIN;
  logic [DATA_WIDTH-1:0] DOUT;
  logic [ADDR_WIDTH-1:0] RADDR;
  logic                  RE;
  logic                  SE;
  logic [ADDR_WIDTH-1:0] WADDR;
  logic                  WE;

  modport master (output DIN, RADDR, RE, SE, WADDR, WE, input DOUT);
  modport slave  (input DIN, RADDR, RE, SE, WADDR, WE, output DOUT);

endinterface

`default_nettype wire

// File: rtl/scm_row_cg.sv
// ============================================================================
// Module : scm_row_cg
// Brief  : Latch-based integrated clock gate for one storage row.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module scm_row_cg (
  input  wire logic CLK,
  input  wire logic EN,
  input  wire logic TE,
  output logic      GCLK
);

  logic r_en_lat;

  // Enable is captured while CLK is low so GCLK never glitches.
  always_latch begin
    if (!CLK) r_en_lat <= EN | TE;
  end

  assign GCLK = CLK & r_en_lat;

endmodule

`default_nettype wire

// File: rtl/scm_65.sv
// ============================================================================
// Module : scm_65
// Brief  : 2**ADDR_WIDTH x DATA_WIDTH standard-cell register file, 1W/1R.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module scm_65
  import scm_pkg::*;
#(
  parameter int ADDR_WIDTH = SCM_ADDR_WIDTH,
  parameter int DATA_WIDTH = SCM_DATA_WIDTH
) (
  input  wire logic CLK,
  input  wire logic RST_N,
  scm_65_if.slave   bus
);

  localparam int ROWS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0]           r_din;
  logic [ADDR_WIDTH-1:0]           r_waddr;
  logic                            r_we;
  logic                            r_se;
  logic [DATA_WIDTH-1:0]           r_dout;
  logic [ROWS-1:0][DATA_WIDTH-1:0] w_rows;
  logic                            w_fwd;
  logic [DATA_WIDTH-1:0]           w_rd_data;

  // Write stage: the request is registered here and committed to the row
  // on the following edge through that row's gated clock.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_din   <= '0;
      r_waddr <= '0;
      r_we    <= 1'b0;
      r_se    <= 1'b0;
    end else begin
      r_we <= bus.WE;
      r_se <= bus.SE;
      if (bus.WE || bus.SE) begin
        r_din   <= bus.DIN;
        r_waddr <= bus.WADDR;
      end
    end
  end

  generate
    for (genvar i = 0; i < ROWS; i++) begin : g_row
      logic                  w_gclk;
      logic [DATA_WIDTH-1:0] r_row;

      scm_row_cg u_cg (
        .CLK  (CLK),
        .EN   (r_we && (r_waddr == ADDR_WIDTH'(i))),
        .TE   (r_se),
        .GCLK (w_gclk)
      );

      always_ff @(posedge w_gclk) begin
        r_row <= r_din;
      end

      assign w_rows[i] = r_row;
    end
  endgenerate

  // A write still sitting in the write stage is not yet in the array, so
  // it is forwarded to keep write-at-k / read-at-k+1 coherent.
  assign w_fwd     = r_se || (r_we && (r_waddr == bus.RADDR));
  assign w_rd_data = w_fwd ? r_din : w_rows[bus.RADDR];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_dout <= '0;
    end else if (bus.RE) begin
      r_dout <= w_rd_data;
    end
  end

  assign bus.DOUT = r_dout;

endmodule

`default_nettype wire

// File: tb/tb_scm_65.sv
// ============================================================================
// Module : tb_scm_65
// Brief  : Directed vector table plus multi-cycle sequences for scm_65.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_scm_65;
  import scm_pkg::*;

  localparam int AW = SCM_ADDR_WIDTH;
  localparam int DW = SCM_DATA_WIDTH;

  typedef struct {
    logic          we;
    logic          re;
    logic          se;
    logic [AW-1:0] waddr;
    logic [AW-1:0] raddr;
    logic [DW-1:0] din;
    logic [DW-1:0] exp_dout;
  } vec_t;

  logic CLK   = 1'b0;
  logic RST_N = 1'b1;
  always #5 CLK = ~CLK;

  scm_65_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  scm_65 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  int            errors = 0;
  int            checks = 0;
  logic [DW-1:0] model [NUM_ROWS];
  logic [DW-1:0] exp_dout = '0;
  vec_t          vecs [14];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock edge; the reference model reads before it writes.
  task automatic cyc(input logic we, input logic re, input logic se,
                     input logic [AW-1:0] wa, input logic [AW-1:0] ra,
                     input logic [DW-1:0] d);
    bus.WE = we; bus.RE = re; bus.SE = se;
    bus.WADDR = wa; bus.RADDR = ra; bus.DIN = d;
    @(posedge CLK);
    #1;
    if (re) exp_dout = model[ra];
    if (se) begin
      for (int r = 0; r < NUM_ROWS; r++) model[r] = d;
    end else if (we) begin
      model[wa] = d;
    end
  endtask

  initial begin
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          w, rd;

    bus.WE = 1'b0; bus.RE = 1'b0; bus.SE = 1'b0;
    bus.WADDR = '0; bus.RADDR = '0; bus.DIN = '0;

    // Asynchronous reset with no clock edge in between.
    #2 RST_N = 1'b0;
    #1 chk("reset_async", bus.DOUT, '0);
    @(posedge CLK); @(posedge CLK);
    #1 RST_N = 1'b1;
    chk("reset_hold", bus.DOUT, '0);

    vecs[0]  = '{1'b1, 1'b0, 1'b0, 6'd3,  6'd0,  64'h0000_0000_DEAD_BEEF, 64'h0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 6'd5,  6'd0,  64'hA5A5_A5A5_A5A5_A5A5, 64'h0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 6'd0,  6'd3,  64'h0,                   64'h0000_0000_DEAD_BEEF};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 6'd7,  6'd5,  64'h77,                  64'hA5A5_A5A5_A5A5_A5A5};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 6'd0,  6'd7,  64'h0,                   64'h77};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 6'd5,  6'd5,  64'h1234,                64'hA5A5_A5A5_A5A5_A5A5};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 6'd0,  6'd5,  64'h0,                   64'h1234};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 6'd0,  6'd0,  64'h0,                   64'h1234};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 6'd63, 6'd3,  64'h6363_6363_6363_6363, 64'h0000_0000_DEAD_BEEF};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 6'd0,  6'd63, 64'h0,                   64'h6363_6363_6363_6363};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 6'd62, 6'd0,  64'hFFFF_FFFF_FFFF_FFFF, 64'h6363_6363_6363_6363};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 6'd0,  6'd62, 64'h0,                   64'hFFFF_FFFF_FFFF_FFFF};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 6'd7,  6'd0,  64'hBAD,                 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 6'd0,  6'd7,  64'h0,                   64'h77};

    for (int i = 0; i < 14; i++) begin
      cyc(vecs[i].we, vecs[i].re, vecs[i].se, vecs[i].waddr, vecs[i].raddr, vecs[i].din);
      chk($sformatf("vec%0d", i), bus.DOUT, vecs[i].exp_dout);
    end

    // Hold and idle for 50 cycles after reading row 3.
    cyc(1'b0, 1'b1, 1'b0, 6'd0, 6'd3, 64'h0);
    chk("hold_read", bus.DOUT, 64'h0000_0000_DEAD_BEEF);
    for (int i = 0; i < 50; i++) begin
      cyc(1'b0, 1'b0, 1'b0, AW'(i), AW'(i), 64'hCAFE);
      chk($sformatf("idle%0d", i), bus.DOUT, 64'h0000_0000_DEAD_BEEF);
    end

    // Mid-cycle async reset must clear DOUT and leave the array alone.
    RST_N = 1'b0;
    #1 chk("reset_mid", bus.DOUT, '0);
    #1 RST_N = 1'b1;
    exp_dout = '0;
    cyc(1'b0, 1'b1, 1'b0, 6'd0, 6'd3, 64'h0);
    chk("post_rst_r3", bus.DOUT, 64'h0000_0000_DEAD_BEEF);
    cyc(1'b0, 1'b1, 1'b0, 6'd0, 6'd5, 64'h0);
    chk("post_rst_r5", bus.DOUT, 64'h1234);
    cyc(1'b0, 1'b1, 1'b0, 6'd0, 6'd63, 64'h0);
    chk("post_rst_r63", bus.DOUT, 64'h6363_6363_6363_6363);

    // Fill every row, then random read-back.
    for (int r = 0; r < NUM_ROWS; r++) begin
      d = {$urandom, $urandom};
      cyc(1'b1, 1'b0, 1'b0, AW'(r), 6'd0, d);
    end
    for (int i = 0; i < 100; i++) begin
      a = AW'($urandom_range(0, NUM_ROWS - 1));
      cyc(1'b0, 1'b1, 1'b0, 6'd0, a, 64'h0);
      chk($sformatf("fill_rd%0d", i), bus.DOUT, exp_dout);
    end

    // Random mixed traffic: forwarding, conflicts and holds all show up here.
    for (int i = 0; i < 1000; i++) begin
      w  = 1'($urandom_range(0, 1));
      rd = 1'($urandom_range(0, 1));
      d  = {$urandom, $urandom};
      cyc(w, rd, 1'b0, AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)), d);
      chk($sformatf("rand%0d", i), bus.DOUT, exp_dout);
    end

    // Scan enable writes every row in one edge.
    cyc(1'b0, 1'b0, 1'b1, 6'd9, 6'd0, 64'hFFFF_0000_FFFF_0000);
    cyc(1'b0, 1'b1, 1'b0, 6'd0, 6'd0, 64'h0);
    chk("scan_r0", bus.DOUT, 64'hFFFF_0000_FFFF_0000);
    cyc(1'b0, 1'b1, 1'b0, 6'd0, 6'd31, 64'h0);
    chk("scan_r31", bus.DOUT, 64'hFFFF_0000_FFFF_0000);
    cyc(1'b0, 1'b1, 1'b0, 6'd0, 6'd63, 64'h0);
    chk("scan_r63", bus.DOUT, 64'hFFFF_0000_FFFF_0000);
    cyc(1'b0, 1'b1, 1'b0, 6'd0, 6'd5, 64'h0);
    chk("scan_r5", bus.DOUT, 64'hFFFF_0000_FFFF_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
